riscv_run_controller: RTL and testbench

Run sequencer for the single-cycle RISC-V core. It loads a program from a host word stream into instruction memory while holding the core in reset, then releases the core. It counts execution cycles until the core raises its finish flag or a cycle budget expires. It sits between the top-level bench/host and the core's rst, finish_flag and IMEM write port.

---
 rtl/riscv_run_controller_if.sv | 34 +++
 rtl/riscv_run_controller.sv | 125 ++++++++++++
 tb/tb_riscv_run_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_run_controller_if.sv
// Host/IMEM/core-control bundle for the run sequencer.
// slave = controller side, master = host/bench side.
interface riscv_run_controller_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              start;
  logic [ADDR_W-1:0] prog_len;
  logic              host_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_rst;
  logic              core_finish;
  logic [CNT_W-1:0]  cycle_count;
  logic              busy;
  logic              done;
  logic              timeout;

  modport slave (
    input  start, prog_len, host_valid, host_data, core_finish,
    output host_ready, imem_we, imem_addr, imem_wdata, core_rst,
           cycle_count, busy, done, timeout
  );

  modport master (
    output start, prog_len, host_valid, host_data, core_finish,
    input  host_ready, imem_we, imem_addr, imem_wdata, core_rst,
           cycle_count, busy, done, timeout
  );
endinterface

// File: rtl/riscv_run_controller.sv
// Loads a program into IMEM with the core held in reset, then runs it and counts cycles.
// IMEM write lands 1 cycle after each host handshake; the host is stalled only outside LOAD.
module riscv_run_controller #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000
) (
  input  logic                   i_clock,
  input  logic                   i_rst,
  riscv_run_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] BUDGET    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] BUDGET_M1 = CNT_W'(MAX_CYCLES - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_idx;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [DATA_W-1:0] r_imem_wdata;
  logic              r_core_rst;
  logic [CNT_W-1:0]  r_cycle_count;
  logic              r_done;
  logic              r_timeout;

  logic w_host_ready;
  logic w_busy;
  logic w_handshake;
  logic w_last_word;

  assign w_host_ready = (r_state == S_LOAD);
  assign w_busy       = (r_state == S_LOAD) || (r_state == S_RELEASE) || (r_state == S_RUN);
  assign w_handshake  = bus.host_valid && w_host_ready;
  assign w_last_word  = (r_idx == (r_len - ADDR_W'(1)));

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_idx         <= '0;
      r_imem_we     <= 1'b0;
      r_imem_addr   <= '0;
      r_imem_wdata  <= '0;
      r_core_rst    <= 1'b1;
      r_cycle_count <= '0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse per accepted word.
      r_imem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_core_rst <= 1'b1;
          if (bus.start) begin
            r_len         <= bus.prog_len;
            r_idx         <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_state       <= (bus.prog_len != '0) ? S_LOAD : S_RELEASE;
          end
        end
        S_LOAD: begin
          r_core_rst <= 1'b1;
          if (w_handshake) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_idx;
            r_imem_wdata <= bus.host_data;
            r_idx        <= r_idx + ADDR_W'(1);
            if (w_last_word) begin
              r_state <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          // Last IMEM write completes here; core leaves reset on the next edge.
          r_core_rst <= 1'b0;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if (bus.core_finish) begin
            r_done     <= 1'b1;
            r_timeout  <= 1'b0;
            r_core_rst <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_cycle_count == BUDGET_M1) begin
            r_cycle_count <= BUDGET;
            r_done        <= 1'b1;
            r_timeout     <= 1'b1;
            r_core_rst    <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_core_rst    <= 1'b0;
            r_cycle_count <= r_cycle_count + CNT_W'(1);
          end
        end
        default: begin
          r_core_rst <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.host_ready  = w_host_ready;
  assign bus.busy        = w_busy;
  assign bus.imem_we     = r_imem_we;
  assign bus.imem_addr   = r_imem_addr;
  assign bus.imem_wdata  = r_imem_wdata;
  assign bus.core_rst    = r_core_rst;
  assign bus.cycle_count = r_cycle_count;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_riscv_run_controller.sv
// Directed bench: IMEM writes are checked against a scoreboard queue filled as words are offered.
module tb_riscv_run_controller;

  localparam int MAXC = 10;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_run_controller_if #(.ADDR_W(8), .DATA_W(32), .CNT_W(32)) bus ();

  riscv_run_controller #(
    .ADDR_W(8), .DATA_W(32), .CNT_W(32), .MAX_CYCLES(MAXC)
  ) dut (
    .i_clock (clk),
    .i_rst   (rst),
    .bus     (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  wr_t         sb[$];
  logic [31:0] prog[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every IMEM strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed write addr %0h, expected none", bus.imem_addr);
      end
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("imem_addr", 64'(bus.imem_addr), 64'(e.addr));
        chk("imem_wdata", 64'(bus.imem_wdata), 64'(e.data));
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "/core_rst"},   64'(bus.core_rst), 1);
    chk({tag, "/host_ready"}, 64'(bus.host_ready), 0);
    chk({tag, "/imem_we"},    64'(bus.imem_we), 0);
    chk({tag, "/imem_addr"},  64'(bus.imem_addr), 0);
    chk({tag, "/imem_wdata"}, 64'(bus.imem_wdata), 0);
    chk({tag, "/cycles"},     64'(bus.cycle_count), 0);
    chk({tag, "/busy"},       64'(bus.busy), 0);
    chk({tag, "/done"},       64'(bus.done), 0);
    chk({tag, "/timeout"},    64'(bus.timeout), 0);
  endtask

  task automatic start_run(input int len, input string tag);
    bus.start      = 1'b1;
    bus.prog_len   = 8'(len);
    bus.host_valid = 1'b1;  // must be ignored outside LOAD
    bus.host_data  = 32'hDEADBEEF;
    tick();
    bus.start      = 1'b0;
    bus.host_valid = 1'b0;
    chk({tag, "/done_clr"},    64'(bus.done), 0);
    chk({tag, "/timeout_clr"}, 64'(bus.timeout), 0);
    chk({tag, "/cycles_clr"},  64'(bus.cycle_count), 0);
    chk({tag, "/busy"},        64'(bus.busy), 1);
  endtask

  // pat bit k (mod 8) is host_valid on the k-th LOAD cycle.
  task automatic load(input int len, input logic [7:0] pat, input string tag);
    int j = 0;
    int k = 0;
    while (j < len && k < 32) begin
      bus.host_valid = pat[k % 8];
      bus.host_data  = prog[j];
      chk({tag, "/host_ready"}, 64'(bus.host_ready), 1);
      chk({tag, "/core_rst_load"}, 64'(bus.core_rst), 1);
      if (bus.host_valid) begin
        sb.push_back('{8'(j), prog[j]});
        j++;
      end
      tick();
      k++;
    end
    bus.host_valid = 1'b0;
    chk({tag, "/release_ready"}, 64'(bus.host_ready), 0);
    chk({tag, "/release_busy"},  64'(bus.busy), 1);
    chk({tag, "/release_rst"},   64'(bus.core_rst), 1);
    tick();
    chk({tag, "/sb_drained"}, 64'(sb.size()), 0);
  endtask

  task automatic run_phase(input int fin_at, input int start_at, input string tag);
    int cc  = 0;
    bit fin = 1'b0;
    bit to  = 1'b0;
    for (int c = 1; c <= MAXC + 2 && !fin; c++) begin
      chk({tag, "/core_rst_run"}, 64'(bus.core_rst), 0);
      chk({tag, "/busy_run"}, 64'(bus.busy), 1);
      bus.core_finish = (c == fin_at);
      bus.start       = (c == start_at);
      tick();
      if (c == fin_at) begin
        fin = 1'b1;
      end else if (cc == MAXC - 1) begin
        cc  = MAXC;
        fin = 1'b1;
        to  = 1'b1;
      end else begin
        cc++;
      end
      if (!fin) chk({tag, "/count"}, 64'(bus.cycle_count), 64'(cc));
    end
    bus.core_finish = 1'b0;
    bus.start       = 1'b0;
    chk({tag, "/final_count"}, 64'(bus.cycle_count), 64'(cc));
    chk({tag, "/done"},        64'(bus.done), 1);
    chk({tag, "/timeout"},     64'(bus.timeout), 64'(to));
    chk({tag, "/core_rst"},    64'(bus.core_rst), 1);
    chk({tag, "/busy"},        64'(bus.busy), 0);
    tick();
    chk({tag, "/hold_count"},  64'(bus.cycle_count), 64'(cc));
    chk({tag, "/hold_done"},   64'(bus.done), 1);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.prog_len    = '0;
    bus.host_valid  = 1'b0;
    bus.host_data   = '0;
    bus.core_finish = 1'b0;
    prog[0] = 32'h00000013;
    prog[1] = 32'h00100093;
    prog[2] = 32'h00000073;
    prog[3] = 32'h00208133;

    rst = 1'b1;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // Back-to-back load, finish on the 5th RUN cycle.
    start_run(3, "t1");
    load(3, 8'hFF, "t1");
    run_phase(5, 0, "t1");

    // Gapped load, then run into the budget.
    start_run(3, "t2");
    load(3, 8'b0101_0101, "t2");
    run_phase(0, 0, "t2");

    // Finish coincides with the last budget cycle: finish wins.
    start_run(3, "t3");
    load(3, 8'hFF, "t3");
    run_phase(MAXC, 0, "t3");

    // Empty program; a start pulse in RUN must not disturb the count.
    start_run(0, "t4");
    load(0, 8'hFF, "t4");
    run_phase(6, 3, "t4");

    // Reset after the first of four words.
    start_run(4, "t5");
    bus.host_valid = 1'b1;
    bus.host_data  = prog[0];
    sb.push_back('{8'd0, prog[0]});
    tick();
    rst            = 1'b1;
    bus.host_data  = prog[1];
    tick();
    rst            = 1'b0;
    bus.host_valid = 1'b0;
    chk_reset("t5_abort");
    chk("t5/sb_after_abort", 64'(sb.size()), 0);
    tick();
    chk("t5/no_write_after_reset", 64'(bus.imem_we), 0);

    start_run(2, "t6");
    load(2, 8'hFF, "t6");
    run_phase(1, 0, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
